// File: rtl/led_panel_capture.sv
// rtl/led_panel_capture.sv - LED panel shift/latch capture into a (row, x, plane, bit) write stream
// Optional 2-sample input deglitch filter: define LED_CAPTURE_DEGLITCH_EN.
`timescale 1ns/1ps
module led_panel_capture #(
  parameter int DISP_ADDR_WIDTH = 3,
  parameter int DISPLAY_WIDTH   = 416,
  parameter int X_WIDTH         = 9,
  parameter int NUM_PLANES      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       panel_clk_in,
  input  logic                       panel_data_in,
  input  logic                       panel_latch_in,
  input  logic [DISP_ADDR_WIDTH-1:0] panel_addr_in,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [DISP_ADDR_WIDTH-1:0] wr_row,
  output logic [X_WIDTH-1:0]         wr_x,
  output logic [2:0]                 wr_plane,
  output logic                       wr_bit,
  output logic                       wr_last,
  output logic                       frame_start,
  output logic                       line_error,
  output logic                       overflow
);
  localparam int IW = DISP_ADDR_WIDTH + 3;
  localparam logic [X_WIDTH-1:0] LINE_LEN   = X_WIDTH'(DISPLAY_WIDTH);
  localparam logic [X_WIDTH-1:0] LAST_X     = X_WIDTH'(DISPLAY_WIDTH - 1);
  localparam logic [2:0]         LAST_PLANE = 3'(NUM_PLANES - 1);

  typedef enum logic {S_IDLE, S_DRAIN} state_e;

  // Input bundle bit order: {addr, latch, data, clk}
  logic [IW-1:0] raw_in, sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, cur;
  logic [IW-1:0] filt_q, filt_d;

  logic                       fill_bank_q, fill_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]                 full_q, full_d;
  logic [DISP_ADDR_WIDTH-1:0] row_mem_q [2];
  logic [DISP_ADDR_WIDTH-1:0] row_mem_d [2];
  logic [2:0]                 plane_mem_q [2];
  logic [2:0]                 plane_mem_d [2];
  logic [DISPLAY_WIDTH-1:0]   line_mem_q [2];
  logic [DISPLAY_WIDTH-1:0]   line_mem_d [2];

  logic [X_WIDTH-1:0]         x_cnt_q, x_cnt_d;
  logic                       too_long_q, too_long_d, blocked_q, blocked_d;
  logic [2:0]                 plane_q, plane_d, next_plane;
  logic [DISP_ADDR_WIDTH-1:0] prev_row_q, prev_row_d;
  logic                       have_prev_q, have_prev_d;

  state_e                     state_q, state_d;
  logic                       wr_valid_q, wr_valid_d, wr_bit_q, wr_bit_d, wr_last_q, wr_last_d;
  logic [DISP_ADDR_WIDTH-1:0] wr_row_q, wr_row_d;
  logic [X_WIDTH-1:0]         wr_x_q, wr_x_d;
  logic [2:0]                 wr_plane_q, wr_plane_d;
  logic                       frame_start_q, frame_start_d, line_error_q, line_error_d;
  logic                       overflow_q, overflow_d;

  logic                       clk_rise, latch_rise, cur_data;
  logic [DISP_ADDR_WIDTH-1:0] cur_addr;
  logic                       ld, ld_bank;
  logic [X_WIDTH-1:0]         ld_x;

  assign raw_in = {panel_addr_in, panel_latch_in, panel_data_in, panel_clk_in};

`ifdef LED_CAPTURE_DEGLITCH_EN
  // The filtered copy follows only when the newest two synced samples agree.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < IW; i++) begin
      if (sync1_q[i] == sync2_q[i]) filt_d[i] = sync2_q[i];
    end
  end
  assign cur = filt_q;
`else
  assign filt_d = sync2_q;
  assign cur    = sync2_q;
`endif

  assign clk_rise   = cur[0] & ~prev_q[0];
  assign latch_rise = cur[2] & ~prev_q[2];
  assign cur_data   = cur[1];
  assign cur_addr   = cur[IW-1:3];

  always_comb begin
    next_plane = 3'd0;
    if (have_prev_q && (cur_addr == prev_row_q) && (plane_q < LAST_PLANE)) begin
      next_plane = plane_q + 3'd1;
    end
  end

  always_comb begin
    sync1_d       = raw_in;
    sync2_d       = sync1_q;
    prev_d        = cur;
    fill_bank_d   = fill_bank_q;
    rd_bank_d     = rd_bank_q;
    full_d        = full_q;
    row_mem_d     = row_mem_q;
    plane_mem_d   = plane_mem_q;
    line_mem_d    = line_mem_q;
    x_cnt_d       = x_cnt_q;
    too_long_d    = too_long_q;
    blocked_d     = blocked_q;
    plane_d       = plane_q;
    prev_row_d    = prev_row_q;
    have_prev_d   = have_prev_q;
    state_d       = state_q;
    wr_valid_d    = wr_valid_q;
    wr_row_d      = wr_row_q;
    wr_x_d        = wr_x_q;
    wr_plane_d    = wr_plane_q;
    wr_bit_d      = wr_bit_q;
    wr_last_d     = wr_last_q;
    frame_start_d = 1'b0;
    line_error_d  = 1'b0;
    overflow_d    = 1'b0;
    ld            = 1'b0;
    ld_bank       = rd_bank_q;
    ld_x          = '0;

    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          ld      = 1'b1;
          state_d = S_DRAIN;
        end
      end
      default: begin
        if (wr_valid_q && wr_ready) begin
          if (wr_last_q) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            if (full_q[~rd_bank_q]) begin
              ld      = 1'b1;
              ld_bank = ~rd_bank_q;
            end else begin
              wr_valid_d = 1'b0;
              wr_last_d  = 1'b0;
              state_d    = S_IDLE;
            end
          end else begin
            ld   = 1'b1;
            ld_x = wr_x_q + 1'b1;
          end
        end
      end
    endcase

    if (ld) begin
      wr_valid_d = 1'b1;
      wr_x_d     = ld_x;
      wr_row_d   = row_mem_q[ld_bank];
      wr_plane_d = plane_mem_q[ld_bank];
      wr_bit_d   = line_mem_q[ld_bank][ld_x];
      wr_last_d  = (ld_x == LAST_X);
    end

    // A line that ever saw its fill bank occupied is dropped at commit.
    if (latch_rise) begin
      x_cnt_d       = '0;
      too_long_d    = 1'b0;
      blocked_d     = 1'b0;
      plane_d       = next_plane;
      prev_row_d    = cur_addr;
      have_prev_d   = 1'b1;
      frame_start_d = (cur_addr == '0) && (next_plane == 3'd0);
      if ((x_cnt_q != LINE_LEN) || too_long_q) begin
        line_error_d = 1'b1;
      end else if (full_q[fill_bank_q] || blocked_q) begin
        overflow_d = 1'b1;
      end else begin
        full_d[fill_bank_q]      = 1'b1;
        row_mem_d[fill_bank_q]   = cur_addr;
        plane_mem_d[fill_bank_q] = next_plane;
        fill_bank_d              = ~fill_bank_q;
      end
    end else if (clk_rise) begin
      if (x_cnt_q < LINE_LEN) begin
        if (full_q[fill_bank_q]) blocked_d = 1'b1;
        else line_mem_d[fill_bank_q][x_cnt_q] = cur_data;
        x_cnt_d = x_cnt_q + 1'b1;
      end else begin
        too_long_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      filt_q        <= '0;
      prev_q        <= '0;
      fill_bank_q   <= 1'b0;
      rd_bank_q     <= 1'b0;
      full_q        <= 2'b00;
      row_mem_q     <= '{default: '0};
      plane_mem_q   <= '{default: '0};
      line_mem_q    <= '{default: '0};
      x_cnt_q       <= '0;
      too_long_q    <= 1'b0;
      blocked_q     <= 1'b0;
      plane_q       <= 3'd0;
      prev_row_q    <= '0;
      have_prev_q   <= 1'b0;
      state_q       <= S_IDLE;
      wr_valid_q    <= 1'b0;
      wr_row_q      <= '0;
      wr_x_q        <= '0;
      wr_plane_q    <= 3'd0;
      wr_bit_q      <= 1'b0;
      wr_last_q     <= 1'b0;
      frame_start_q <= 1'b0;
      line_error_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      filt_q        <= filt_d;
      prev_q        <= prev_d;
      fill_bank_q   <= fill_bank_d;
      rd_bank_q     <= rd_bank_d;
      full_q        <= full_d;
      row_mem_q     <= row_mem_d;
      plane_mem_q   <= plane_mem_d;
      line_mem_q    <= line_mem_d;
      x_cnt_q       <= x_cnt_d;
      too_long_q    <= too_long_d;
      blocked_q     <= blocked_d;
      plane_q       <= plane_d;
      prev_row_q    <= prev_row_d;
      have_prev_q   <= have_prev_d;
      state_q       <= state_d;
      wr_valid_q    <= wr_valid_d;
      wr_row_q      <= wr_row_d;
      wr_x_q        <= wr_x_d;
      wr_plane_q    <= wr_plane_d;
      wr_bit_q      <= wr_bit_d;
      wr_last_q     <= wr_last_d;
      frame_start_q <= frame_start_d;
      line_error_q  <= line_error_d;
      overflow_q    <= overflow_d;
    end
  end

  assign wr_valid    = wr_valid_q;
  assign wr_row      = wr_row_q;
  assign wr_x        = wr_x_q;
  assign wr_plane    = wr_plane_q;
  assign wr_bit      = wr_bit_q;
  assign wr_last     = wr_last_q;
  assign frame_start = frame_start_q;
  assign line_error  = line_error_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_led_panel_capture.sv
// tb/tb_led_panel_capture.sv - directed self-checking bench for led_panel_capture
`timescale 1ns/1ps
module tb_led_panel_capture;
  localparam int AW = 3;
  localparam int DW = 416;
  localparam int XW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          panel_clk = 1'b0, panel_data = 1'b0, panel_latch = 1'b0;
  logic [AW-1:0] panel_addr = '0;
  logic          wr_ready = 1'b1;
  logic          wr_valid, wr_bit, wr_last, frame_start, line_error, overflow;
  logic [AW-1:0] wr_row;
  logic [XW-1:0] wr_x;
  logic [2:0]    wr_plane;

  led_panel_capture dut (
    .clk(clk), .reset(reset),
    .panel_clk_in(panel_clk), .panel_data_in(panel_data),
    .panel_latch_in(panel_latch), .panel_addr_in(panel_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_x(wr_x),
    .wr_plane(wr_plane), .wr_bit(wr_bit), .wr_last(wr_last),
    .frame_start(frame_start), .line_error(line_error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     row;
    int     x;
    int     plane;
    int     b;
    int     last;
    longint stamp;
  } beat_t;

  beat_t  beats[$];
  int     n_cmp = 0, n_fail = 0;
  int     err_cnt = 0, ovf_cnt = 0, fs_cnt = 0;
  longint cyc = 0;
  longint last_stamp = 0;

  always @(negedge clk) begin
    beat_t nb;
    cyc = cyc + 1;
    if (reset) begin
      if (wr_valid && wr_ready) begin
        nb.row = int'(wr_row); nb.x = int'(wr_x); nb.plane = int'(wr_plane);
        nb.b = int'(wr_bit); nb.last = int'(wr_last); nb.stamp = cyc;
        beats.push_back(nb);
      end
      if (line_error)  err_cnt++;
      if (overflow)    ovf_cnt++;
      if (frame_start) fs_cnt++;
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic pat(input int k, input int x);
    if (k == 0) return ~x[0];
    return (((x * k) + k) % 5) < 2;
  endfunction

  task automatic send_bits(input int n, input int k);
    for (int i = 0; i < n; i++) begin
      panel_data = pat(k, i);
      tick(2);
      panel_clk = 1'b1;
      tick(2);
      panel_clk = 1'b0;
    end
    tick(2);
  endtask

  task automatic do_latch(input int row);
    panel_addr = AW'(row);
    tick(2);
    panel_latch = 1'b1;
    tick(2);
    panel_latch = 1'b0;
    tick(2);
  endtask

  task automatic check_line(input string tag, input int row, input int plane, input int k,
                            input bit contig_prev);
    int w = 0;
    int n, e_row, e_plane, e_x, e_bit, e_last, e_gap;
    beat_t b;
    longint prev;
    while (beats.size() < DW && w < 3000) begin
      tick(1);
      w++;
    end
    check({tag, "_beats"}, (beats.size() >= DW) ? DW : beats.size(), DW);
    n = (beats.size() >= DW) ? DW : beats.size();
    e_row = 0; e_plane = 0; e_x = 0; e_bit = 0; e_last = 0; e_gap = 0;
    prev = last_stamp;
    for (int i = 0; i < n; i++) begin
      b = beats.pop_front();
      if (b.row != row) e_row++;
      if (b.plane != plane) e_plane++;
      if (b.x != i) e_x++;
      if (b.b != int'(pat(k, i))) e_bit++;
      if (b.last != ((i == DW - 1) ? 1 : 0)) e_last++;
      if ((i > 0 || contig_prev) && b.stamp != prev + 1) e_gap++;
      prev = b.stamp;
    end
    last_stamp = prev;
    check({tag, "_row_errs"}, e_row, 0);
    check({tag, "_plane_errs"}, e_plane, 0);
    check({tag, "_x_errs"}, e_x, 0);
    check({tag, "_bit_errs"}, e_bit, 0);
    check({tag, "_last_errs"}, e_last, 0);
    check({tag, "_gap_errs"}, e_gap, 0);
  endtask

  initial begin
    int lat;
    int w;
    // Reset state
    tick(3);
    check("reset_outputs",
          {wr_valid, wr_last, wr_bit, wr_x, wr_row, wr_plane, frame_start, line_error, overflow}, 0);
    reset = 1'b1;
    tick(3);

    // Alternating line on row 3, with commit-to-valid latency
    send_bits(DW, 0);
    panel_addr = 3'd3;
    tick(2);
    panel_latch = 1'b1;
    lat = 0;
    while (!wr_valid && lat < 20) begin
      tick(1);
      lat++;
    end
`ifdef LED_CAPTURE_DEGLITCH_EN
    check("first_valid_latency", lat, 5);
`else
    check("first_valid_latency", lat, 4);
`endif
    panel_latch = 1'b0;
    tick(2);
    check_line("alt_row3", 3, 0, 0, 1'b0);

    // Plane sequencing on row 5, wrap, then row 6
    send_bits(DW, 1); do_latch(5); check_line("r5_p0", 5, 0, 1, 1'b0);
    send_bits(DW, 2); do_latch(5); check_line("r5_p1", 5, 1, 2, 1'b0);
    for (int i = 0; i < 5; i++) do_latch(5);
    send_bits(DW, 3); do_latch(5); check_line("r5_p7", 5, 7, 3, 1'b0);
    send_bits(DW, 4); do_latch(5); check_line("r5_wrap", 5, 0, 4, 1'b0);
    do_latch(5);
    send_bits(DW, 5); do_latch(6); check_line("r6_p0", 6, 0, 5, 1'b0);
    check("errors_after_planes", err_cnt, 6);

    // Short and long lines
    send_bits(DW - 1, 1); do_latch(6);
    send_bits(DW + 1, 2); do_latch(6);
    tick(600);
    check("errors_after_badlen", err_cnt, 8);
    check("no_beats_badlen", beats.size(), 0);

    // Back-pressure: two banks fill, third line overflows
    wr_ready = 1'b0;
    send_bits(DW, 6); do_latch(1);
    send_bits(DW, 7); do_latch(2);
    send_bits(DW, 8); do_latch(3);
    tick(4);
    check("overflow_count", ovf_cnt, 1);
    check("hold_valid", wr_valid, 1);
    check("hold_row", wr_row, 1);
    tick(5);
    check("hold_x", wr_x, 0);
    check("hold_bit", wr_bit, pat(6, 0));
    check("hold_no_beats", beats.size(), 0);
    wr_ready = 1'b1;
    check_line("bp_line1", 1, 0, 6, 1'b0);
    check_line("bp_line2", 2, 0, 7, 1'b1);
    tick(600);
    check("bp_no_third", beats.size(), 0);
    check("bp_overflow_final", ovf_cnt, 1);

    // Frame start after row 7 plane 7, then a single-sample latch glitch
    for (int i = 0; i < 8; i++) do_latch(7);
    check("no_frame_yet", fs_cnt, 0);
    do_latch(0);
    check("frame_start_count", fs_cnt, 1);
    check("errors_after_frame", err_cnt, 17);
    send_bits(DW, 9);
    panel_addr = 3'd0;
    tick(2);
    panel_latch = 1'b1;
    tick(1);
    panel_latch = 1'b0;
    tick(4);
`ifdef LED_CAPTURE_DEGLITCH_EN
    tick(600);
    check("glitch_ignored", beats.size(), 0);
    do_latch(0);
    check_line("flush_r0_p1", 0, 1, 9, 1'b0);
`else
    check_line("glitch_r0_p1", 0, 1, 9, 1'b0);
`endif
    check("frame_start_final", fs_cnt, 1);

    // Reset mid-drain
    wr_ready = 1'b1;
    send_bits(DW, 10); do_latch(4);
    w = 0;
    while (beats.size() < 100 && w < 2000) begin
      tick(1);
      w++;
    end
    check("middrain_started", (beats.size() >= 100) ? 1 : 0, 1);
    reset = 1'b0;
    #1;
    check("reset_async_outputs",
          {wr_valid, wr_last, wr_bit, wr_x, wr_row, wr_plane, frame_start, line_error, overflow}, 0);
    tick(1);
    check("reset_next_cycle",
          {wr_valid, wr_last, wr_bit, wr_x, wr_row, wr_plane, frame_start, line_error, overflow}, 0);
    reset = 1'b1;
    beats.delete();
    tick(800);
    check("no_resume_after_reset", beats.size(), 0);
    check("idle_after_reset", wr_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
